// File: rtl/dct_pkg.sv
// Shared constants for the 8-point DCT datapath: cos(k*pi/16) scaled by 2^FRAC.
package dct_pkg;
  localparam int FRAC = 8;
  localparam int C1   = 251;
  localparam int C2   = 237;
  localparam int C3   = 213;
  localparam int C4   = 181;
  localparam int C5   = 142;
  localparam int C6   = 98;
  localparam int C7   = 50;
endpackage

// File: rtl/dct8_1d_pipe_if.sv
// Vector stream bus for one 1-D DCT pass: 8 samples in, 8 coefficients out.
interface dct8_1d_pipe_if #(
  parameter int BW  = 8,
  parameter int OBW = BW + 4
);
  logic               i_en;
  logic [8*BW-1:0]    i_data;
  logic               o_en;
  logic [8*OBW-1:0]   o_data;
  logic               o_last;

  modport master (output i_en, i_data, input  o_en, o_data, o_last);
  modport slave  (input  i_en, i_data, output o_en, o_data, o_last);
endinterface

// File: rtl/dct_round_sat.sv
// Round-half-up by 2^(FRAC+1) and clamp one accumulator into an OBW-bit coefficient.
module dct_round_sat #(
  parameter int AW   = 21,
  parameter int OBW  = 12,
  parameter int FRAC = 8
) (
  input  logic signed [AW-1:0]  i_acc,
  output logic signed [OBW-1:0] o_val
);
  localparam logic signed [AW-1:0] HALF  = AW'(1 << FRAC);
  localparam logic signed [AW-1:0] MAX_V = AW'((1 << (OBW-1)) - 1);
  localparam logic signed [AW-1:0] MIN_V = AW'(-(1 << (OBW-1)));

  logic signed [AW-1:0] rnd;
  logic signed [AW-1:0] sh;

  always_comb begin
    rnd   = i_acc + HALF;
    sh    = rnd >>> (FRAC + 1);
    o_val = OBW'(sh);
    if (sh > MAX_V) begin
      o_val = OBW'(MAX_V);
    end else if (sh < MIN_V) begin
      o_val = OBW'(MIN_V);
    end
  end
endmodule

// File: rtl/dct8_1d_pipe.sv
// Three-stage pipelined 8-point DCT-II: butterfly, constant multiply-accumulate,
// round/saturate. Fixed 3-cycle latency, bubbles pass through as o_en=0.
module dct8_1d_pipe #(
  parameter int BW   = 8,
  parameter int OBW  = BW + 4,
  parameter int FRAC = dct_pkg::FRAC
) (
  input  logic          i_clk,
  input  logic          i_Reset,
  dct8_1d_pipe_if.slave bus
);
  import dct_pkg::*;

  localparam int SW = BW + 1;
  localparam int EW = BW + 2;
  localparam int AW = BW + FRAC + 5;

  localparam logic signed [AW-1:0] K1 = AW'(C1);
  localparam logic signed [AW-1:0] K2 = AW'(C2);
  localparam logic signed [AW-1:0] K3 = AW'(C3);
  localparam logic signed [AW-1:0] K4 = AW'(C4);
  localparam logic signed [AW-1:0] K5 = AW'(C5);
  localparam logic signed [AW-1:0] K6 = AW'(C6);
  localparam logic signed [AW-1:0] K7 = AW'(C7);

  logic signed [BW-1:0]  x     [8];
  logic signed [SW-1:0]  s_d   [4];
  logic signed [SW-1:0]  s_q   [4];
  logic signed [SW-1:0]  d_d   [4];
  logic signed [SW-1:0]  d_q   [4];
  logic signed [EW-1:0]  e     [4];
  logic signed [AW-1:0]  ew    [4];
  logic signed [AW-1:0]  dw    [4];
  logic signed [AW-1:0]  acc_d [8];
  logic signed [AW-1:0]  acc_q [8];
  logic signed [OBW-1:0] y     [8];
  logic [8*OBW-1:0]      o_data_d, o_data_q;
  logic [2:0]            v_d, v_q;
  logic [2:0]            cnt_d, cnt_q;
  logic                  o_last_d, o_last_q;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign x[gi] = bus.i_data[8*BW-1-gi*BW -: BW];
      dct_round_sat #(.AW(AW), .OBW(OBW), .FRAC(FRAC)) u_rs (
        .i_acc (acc_q[gi]),
        .o_val (y[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      s_d[n] = SW'(x[n]) + SW'(x[7-n]);
      d_d[n] = SW'(x[n]) - SW'(x[7-n]);
    end
  end

  // Even half uses the second butterfly; odd half multiplies the differences directly.
  always_comb begin
    e[0] = EW'(s_q[0]) + EW'(s_q[3]);
    e[1] = EW'(s_q[1]) + EW'(s_q[2]);
    e[2] = EW'(s_q[0]) - EW'(s_q[3]);
    e[3] = EW'(s_q[1]) - EW'(s_q[2]);
    for (int n = 0; n < 4; n++) begin
      ew[n] = AW'(e[n]);
      dw[n] = AW'(d_q[n]);
    end
    acc_d[0] = (ew[0] + ew[1]) * K4;
    acc_d[4] = (ew[0] - ew[1]) * K4;
    acc_d[2] = ew[2] * K2 + ew[3] * K6;
    acc_d[6] = ew[2] * K6 - ew[3] * K2;
    acc_d[1] = dw[0] * K1 + dw[1] * K3 + dw[2] * K5 + dw[3] * K7;
    acc_d[3] = dw[0] * K3 - dw[1] * K7 - dw[2] * K1 - dw[3] * K5;
    acc_d[5] = dw[0] * K5 - dw[1] * K1 + dw[2] * K7 + dw[3] * K3;
    acc_d[7] = dw[0] * K7 - dw[1] * K5 + dw[2] * K3 - dw[3] * K1;
  end

  // The block counter tracks vectors entering the output register, so o_last lines up with o_en.
  always_comb begin
    o_data_d = '0;
    for (int k = 0; k < 8; k++) begin
      o_data_d[8*OBW-1-k*OBW -: OBW] = y[k];
    end
    v_d      = {v_q[1:0], bus.i_en};
    cnt_d    = cnt_q + {2'b00, v_q[1]};
    o_last_d = v_q[1] & (cnt_q == 3'd7);
  end

  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      for (int n = 0; n < 4; n++) begin
        s_q[n] <= '0;
        d_q[n] <= '0;
      end
      for (int k = 0; k < 8; k++) begin
        acc_q[k] <= '0;
      end
      o_data_q <= '0;
      v_q      <= '0;
      cnt_q    <= '0;
      o_last_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      d_q      <= d_d;
      acc_q    <= acc_d;
      o_data_q <= o_data_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      o_last_q <= o_last_d;
    end
  end

  assign bus.o_en   = v_q[2];
  assign bus.o_data = o_data_q;
  assign bus.o_last = o_last_q;
endmodule
